tf_block_ctrl: RTL

Iterative sequencer for one Threefish-1024 block encryption inside the Skein hash core. It accepts a key, tweak and plaintext, and computes the key extension and all 21 subkeys. It drives a single shared combinational round datapath (add/rotate/permute) for 80 cycles, then performs the final subkey injection and holds the ciphertext until the consumer accepts it.

---
 rtl/tf_pkg.sv | 66 ++++++
 rtl/tf_block_ctrl_if.sv | 27 ++
 rtl/tf_subkey_gen.sv | 34 +++
 rtl/tf_block_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/tf_pkg.sv
// Shared constants, types and helpers for the Threefish-1024 block sequencer
// and its combinational round datapath.
package tf_pkg;

    localparam int unsigned WW     = 64;
    localparam int unsigned NW     = 16;
    localparam int unsigned NS     = 21;
    localparam int unsigned NR_DEF = 80;
    localparam int unsigned SW     = $clog2(NS);

    localparam logic [WW-1:0] C240 = 64'h1BD1_1BDA_A9FC_1A22;

    // Rotation constants R[d][j], d = round mod 8, j = MIX pair index.
    localparam int unsigned TF_ROT [8][8] = '{
        '{24, 13,  8, 47,  8, 17, 22, 37},
        '{38, 19, 10, 55, 49, 18, 23, 52},
        '{33,  4, 51, 13, 34, 41, 59, 17},
        '{ 5, 20, 48, 41, 47, 28, 16, 25},
        '{41,  9, 37, 31, 12, 47, 44, 30},
        '{16, 34, 56, 51,  4, 53, 42, 41},
        '{31, 44, 47, 46, 19, 42, 44, 25},
        '{ 9, 48, 35, 52, 23, 31, 37, 20}
    };

    typedef logic [WW-1:0] word_t;
    typedef word_t [NW-1:0] block_t;
    typedef word_t [NW:0]   kext_t;
    typedef word_t [2:0]    text_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } tf_state_e;

    // K16 parity word appended to the user key.
    function automatic kext_t key_extend(input block_t k);
        kext_t r;
        word_t x;
        x = C240;
        for (int i = 0; i < NW; i++) begin
            r[i] = k[i];
            x    = x ^ k[i];
        end
        r[NW] = x;
        return r;
    endfunction

    function automatic text_t tweak_extend(input logic [2*WW-1:0] tw);
        text_t r;
        r[0] = tw[WW-1:0];
        r[1] = tw[2*WW-1:WW];
        r[2] = r[0] ^ r[1];
        return r;
    endfunction

    function automatic block_t add_words(input block_t a, input block_t b);
        block_t r;
        for (int i = 0; i < NW; i++) begin
            r[i] = a[i] + b[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/tf_block_ctrl_if.sv
// Job, datapath and result signals between the sequencer and its environment.
interface tf_block_ctrl_if;
    import tf_pkg::*;

    logic             in_valid;
    logic             in_ready;
    block_t           key;
    logic [2*WW-1:0]  tweak;
    block_t           plaintext;
    logic [2:0]       rnd_idx;
    block_t           round_pt;
    block_t           round_ct;
    logic             out_valid;
    logic             out_ready;
    block_t           cyphertext;

    modport master (
        output in_valid, key, tweak, plaintext, round_ct, out_ready,
        input  in_ready, rnd_idx, round_pt, out_valid, cyphertext
    );

    modport slave (
        input  in_valid, key, tweak, plaintext, round_ct, out_ready,
        output in_ready, rnd_idx, round_pt, out_valid, cyphertext
    );

endinterface

// File: rtl/tf_subkey_gen.sv
// Combinational Threefish-1024 key schedule: subkey s from the extended key
// and tweak.
module tf_subkey_gen
    import tf_pkg::*;
(
    input  kext_t          k_i,
    input  text_t          t_i,
    input  logic [SW-1:0]  s_i,
    output block_t         subkey_o
);

    logic [1:0] t_a;
    logic [1:0] t_b;
    logic [5:0] kidx_sum;

    always_comb begin : tweak_sel
        t_a = 2'(s_i % SW'(3));
        t_b = (t_a == 2'd2) ? 2'd0 : t_a + 2'd1;
    end

    // Word i rotates through the 17 extended key words.
    always_comb begin : subkey_words
        kidx_sum = '0;
        subkey_o = '0;
        for (int i = 0; i < NW; i++) begin
            kidx_sum    = 6'(s_i) + 6'(i);
            subkey_o[i] = k_i[5'(kidx_sum % 6'd17)];
        end
        subkey_o[13] = subkey_o[13] + t_i[t_a];
        subkey_o[14] = subkey_o[14] + t_i[t_b];
        subkey_o[15] = subkey_o[15] + WW'(s_i);
    end

endmodule

// File: rtl/tf_block_ctrl.sv
// Iterative Threefish-1024 block sequencer driving an external combinational
// round datapath for NR cycles, then injecting the final subkey.
module tf_block_ctrl
    import tf_pkg::*;
#(
    parameter int unsigned NR = NR_DEF
) (
    input  logic           clk,
    input  logic           reset,
    tf_block_ctrl_if.slave bus
);

    localparam int unsigned     RND_W    = $clog2(NR);
    localparam logic [RND_W-1:0] RND_LAST = RND_W'(NR - 1);

    tf_state_e         state_q, state_d;
    block_t            st_q, st_d;
    kext_t             k_q, k_d;
    text_t             t_q, t_d;
    logic [RND_W-1:0]  rnd_q, rnd_d;
    logic [SW-1:0]     s_q, s_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [2:0]        rnd_idx_q, rnd_idx_d;
    block_t            subkey;
    block_t            round_pt_c;

    // s reaches NR/4 on the last RUN cycle, so FINAL picks up the last subkey.
    tf_subkey_gen u_subkey (
        .k_i      (k_q),
        .t_i      (t_q),
        .s_i      (s_q),
        .subkey_o (subkey)
    );

    always_ff @(posedge clk) begin : state_reg
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.in_valid) state_d = ST_RUN;
            ST_RUN:   if (rnd_q == RND_LAST) state_d = ST_FINAL;
            ST_FINAL: state_d = ST_DONE;
            ST_DONE:  if (bus.out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin : outputs
        st_d       = st_q;
        k_d        = k_q;
        t_d        = t_q;
        rnd_d      = rnd_q;
        s_d        = s_q;
        round_pt_c = st_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    st_d  = bus.plaintext;
                    k_d   = key_extend(bus.key);
                    t_d   = tweak_extend(bus.tweak);
                    rnd_d = '0;
                    s_d   = '0;
                end
            end
            ST_RUN: begin
                if (rnd_q[1:0] == 2'd0) begin
                    round_pt_c = add_words(st_q, subkey);
                end
                st_d  = bus.round_ct;
                rnd_d = (rnd_q == RND_LAST) ? '0 : rnd_q + RND_W'(1);
                if (rnd_q[1:0] == 2'd3) begin
                    s_d = s_q + SW'(1);
                end
            end
            ST_FINAL: st_d = add_words(st_q, subkey);
            default: ;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        rnd_idx_d   = (state_d == ST_RUN) ? rnd_d[2:0] : 3'd0;
    end

    always_ff @(posedge clk) begin : data_reg
        if (reset) begin
            st_q        <= '0;
            k_q         <= '0;
            t_q         <= '0;
            rnd_q       <= '0;
            s_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            rnd_idx_q   <= 3'd0;
        end else begin
            st_q        <= st_d;
            k_q         <= k_d;
            t_q         <= t_d;
            rnd_q       <= rnd_d;
            s_q         <= s_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            rnd_idx_q   <= rnd_idx_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.rnd_idx    = rnd_idx_q;
    assign bus.round_pt   = round_pt_c;
    assign bus.cyphertext = st_q;

endmodule
